// File: rtl/onehot_priority_mux_if.sv
// Bundle of the arbitration-core signals: request/grant side and the one-hot data mux.
// The master side drives requests, hold control and mux inputs; the slave is the arbiter core.
interface onehot_priority_mux_if #(
  parameter int W_INPUT = 2,
  parameter int W_DATA  = 32
);
  logic                        canchange;
  logic [W_INPUT-1:0]          req;
  logic [W_INPUT-1:0]          gnt;
  logic [W_INPUT-1:0]          mux_sel;
  logic [W_INPUT*W_DATA-1:0]   mux_in;
  logic [W_DATA-1:0]           mux_out;

  modport master (
    output canchange, req, mux_sel, mux_in,
    input  gnt, mux_out
  );

  modport slave (
    input  canchange, req, mux_sel, mux_in,
    output gnt, mux_out
  );
endinterface

// File: rtl/onehot_priority_mux.sv
// Strict-priority one-hot grant (lowest index wins) with grant hold, plus an AND-OR one-hot mux.
// Define ONEHOT_PRIORITY_MUX_CHECK_EN to enable a simulation-only one-hot checker on gnt/mux_sel.
module onehot_priority_mux #(
  parameter int W_INPUT = 2,
  parameter int W_DATA  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_priority_mux_if.slave  bus
);

  logic [W_INPUT-1:0] pri_gnt;
  logic [W_INPUT-1:0] gnt_d;
  logic [W_INPUT-1:0] gnt_q;
  logic [W_DATA-1:0]  mux_d;

  // Isolate the lowest set bit: x & -x leaves only that bit, and 0 maps to 0.
  assign pri_gnt = bus.req & ((~bus.req) + W_INPUT'(1));

  // Re-arbitrate when allowed, otherwise repeat last cycle's grant regardless of req.
  assign gnt_d   = bus.canchange ? pri_gnt : gnt_q;
  assign bus.gnt = gnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
    end
  end

  // NOTE: the accumulator is defaulted before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    mux_d = '0;
    for (int i = 0; i < W_INPUT; i++) begin
      mux_d |= bus.mux_in[i*W_DATA +: W_DATA] & {W_DATA{bus.mux_sel[i]}};
    end
  end

  assign bus.mux_out = mux_d;

`ifdef ONEHOT_PRIORITY_MUX_CHECK_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if ($countones(bus.mux_sel) > 1) begin
        $display("%m: mux_sel not one-hot: %b", bus.mux_sel);
        $finish;
      end
      if ($countones(gnt_d) > 1) begin
        $display("%m: gnt not one-hot: %b", gnt_d);
        $finish;
      end
    end
  end
`else
  // Checker absent; behaviour is identical.
`endif

endmodule

// File: tb/tb_onehot_priority_mux.sv
// Directed bench for onehot_priority_mux (W_INPUT=4, W_DATA=8) with a short random regression
// against an independent reference model.
module tb_onehot_priority_mux;
  localparam int WI = 4;
  localparam int WD = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [WI-1:0] model_q;

  onehot_priority_mux_if #(.W_INPUT(WI), .W_DATA(WD)) bus ();

  onehot_priority_mux #(.W_INPUT(WI), .W_DATA(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WI-1:0] ref_gnt(input logic cc, input logic [WI-1:0] r,
                                            input logic [WI-1:0] hold);
    logic [WI-1:0] g;
    g = '0;
    if (!cc) return hold;
    for (int i = WI - 1; i >= 0; i--) if (r[i]) g = '0 | (WI'(1) << i);
    return g;
  endfunction

  function automatic logic [WD-1:0] ref_mux(input logic [WI-1:0] sel,
                                            input logic [WI*WD-1:0] lanes);
    logic [WD-1:0] o;
    o = '0;
    for (int i = 0; i < WI; i++) if (sel[i]) o = o | lanes[i*WD +: WD];
    return o;
  endfunction

  // Advance one rising edge, updating the model's held grant, and land 1 time unit after it.
  task automatic tick();
    logic [WI-1:0] nxt;
    nxt = ref_gnt(bus.canchange, bus.req, model_q);
    @(posedge clk);
    model_q = rst_n ? nxt : '0;
    #1;
  endtask

  task automatic drive(input logic cc, input logic [WI-1:0] r);
    bus.canchange = cc;
    bus.req       = r;
    #1;
  endtask

  initial begin
    logic [WI-1:0] sel;
    int            k;
    n_cmp   = 0;
    n_err   = 0;
    model_q = '0;
    rst_n   = 1'b0;
    bus.mux_sel = '0;
    bus.mux_in  = {8'h88, 8'h44, 8'h22, 8'h11};

    // Reset behaviour: hold path reads the cleared register, priority path stays live.
    drive(1'b0, 4'b1111);
    check("rst_hold_zero", 32'(bus.gnt), 32'h0);
    drive(1'b1, 4'b1010);
    check("rst_pri_live", 32'(bus.gnt), 32'h2);
    tick();
    drive(1'b0, 4'b1010);
    check("rst_after_edge_hold", 32'(bus.gnt), 32'h0);
    rst_n = 1'b1;

    // Priority selection.
    drive(1'b1, 4'b1010);
    check("pri_1010", 32'(bus.gnt), 32'h2);
    drive(1'b1, 4'b1000);
    check("pri_1000", 32'(bus.gnt), 32'h8);
    drive(1'b1, 4'b0000);
    check("pri_0000", 32'(bus.gnt), 32'h0);
    tick();
    drive(1'b0, 4'b0110);
    check("held_zero", 32'(bus.gnt), 32'h0);

    // Hold against pre-emption.
    drive(1'b1, 4'b0100);
    check("grant_0100", 32'(bus.gnt), 32'h4);
    tick();
    drive(1'b0, 4'b0001);
    for (int c = 0; c < 3; c++) begin
      check("no_preempt", 32'(bus.gnt), 32'h4);
      tick();
    end
    check("no_preempt_end", 32'(bus.gnt), 32'h4);
    drive(1'b1, 4'b0001);
    check("rearb_same_cycle", 32'(bus.gnt), 32'h1);
    tick();

    // Hold persists after request drops.
    drive(1'b1, 4'b0010);
    check("grant_0010", 32'(bus.gnt), 32'h2);
    tick();
    drive(1'b0, 4'b0000);
    check("drop_hold_0", 32'(bus.gnt), 32'h2);
    tick();
    check("drop_hold_1", 32'(bus.gnt), 32'h2);
    drive(1'b1, 4'b0000);
    check("drop_release", 32'(bus.gnt), 32'h0);
    tick();

    // Async reset mid-hold.
    drive(1'b1, 4'b1000);
    tick();
    drive(1'b0, 4'b0001);
    check("hold_1000", 32'(bus.gnt), 32'h8);
    rst_n   = 1'b0;
    model_q = '0;
    #1;
    check("async_rst_clear", 32'(bus.gnt), 32'h0);
    rst_n = 1'b1;
    #1;
    check("after_rst_release", 32'(bus.gnt), 32'h0);
    tick();

    // canchange toggling every cycle.
    drive(1'b1, 4'b0110);
    check("toggle_arb0", 32'(bus.gnt), 32'h2);
    tick();
    drive(1'b0, 4'b0001);
    check("toggle_hold0", 32'(bus.gnt), 32'h2);
    tick();
    drive(1'b1, 4'b1100);
    check("toggle_arb1", 32'(bus.gnt), 32'h4);
    tick();
    drive(1'b0, 4'b0011);
    check("toggle_hold1", 32'(bus.gnt), 32'h4);
    tick();

    // Mux selection; the multi-hot case is restored before the next edge.
    bus.mux_sel = 4'b0100; #1;
    check("mux_lane2", 32'(bus.mux_out), 32'h44);
    bus.mux_sel = 4'b0000; #1;
    check("mux_none", 32'(bus.mux_out), 32'h00);
    bus.mux_sel = 4'b1000; #1;
    check("mux_lane3", 32'(bus.mux_out), 32'h88);
    bus.mux_sel = 4'b0001; #1;
    check("mux_lane0", 32'(bus.mux_out), 32'h11);
`ifndef ONEHOT_PRIORITY_MUX_CHECK_EN
    bus.mux_sel = 4'b0011; #1;
    check("mux_multi_or", 32'(bus.mux_out), 32'h33);
`endif
    bus.mux_sel = 4'b0000;
    tick();

    // Random regression against the reference model.
    for (int n = 0; n < 2000; n++) begin
      k   = $urandom_range(0, WI);
      sel = (k == WI) ? '0 : (WI'(1) << k);
      bus.mux_sel   = sel;
      bus.mux_in    = {WI*WD{1'b0}} | {$urandom, $urandom};
      bus.canchange = 1'($urandom_range(0, 1));
      bus.req       = WI'($urandom);
      #1;
      check("rand_gnt", 32'(bus.gnt), 32'(ref_gnt(bus.canchange, bus.req, model_q)));
      check("rand_mux", 32'(bus.mux_out), 32'(ref_mux(bus.mux_sel, bus.mux_in)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
